// File: rtl/step_pkg.sv
// step_ctrl shared encodings: CPU run modes and debounce FSM states.
// Optional build macro for the enable counter: STEP_CNT_EN.
package step_pkg;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  typedef enum logic [1:0] {
    DB_IDLE  = 2'b00,
    DB_PRESS = 2'b01,
    DB_HELD  = 2'b10,
    DB_REL   = 2'b11
  } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Step button synchronizer and debounce FSM.
// Emits one step_pulse per accepted press.
module btn_debounce
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic      clk_in,
  input  logic      rst,
  input  logic      btn_step,
  output logic      step_pulse,
  output db_state_t db_state
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST =
    DW'(DEBOUNCE_CYCLES - 1);

  logic          btn_s1, btn_s2;
  db_state_t     state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      state_q <= DB_IDLE;
      dcnt_q  <= '0;
    end else begin
      btn_s1  <= btn_step;
      btn_s2  <= btn_s1;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    step_pulse = 1'b0;
    unique case (state_q)
      DB_IDLE: begin
        if (btn_s2) begin
          state_d = DB_PRESS;
          dcnt_d  = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s2) begin
          state_d = DB_IDLE;
        end else if (dcnt_q == DLAST) begin
          state_d    = DB_HELD;
          step_pulse = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      DB_HELD: begin
        if (!btn_s2) begin
          state_d = DB_REL;
          dcnt_d  = '0;
        end
      end
      DB_REL: begin
        if (btn_s2) begin
          state_d = DB_HELD;
        end else if (dcnt_q == DLAST) begin
          state_d = DB_IDLE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

  assign db_state = state_q;

endmodule

// File: rtl/step_ctrl.sv
// CPU clock-enable generator: RUN ticks, debounced STEP, HALT.
// Define STEP_CNT_EN to build the en_cnt pulse counter.
module step_ctrl
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 32
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             btn_step,
  input  logic [1:0]       mode,
  output logic             cpu_en,
  output logic [CNT_W-1:0] en_cnt,
  output logic [1:0]       dbg_state
);

  logic       tick_s1, tick_s2, tick_prev;
  logic [1:0] mode_s1, mode_s2;
  logic       tick_rise, step_pulse, en_d;
  db_state_t  db_state;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk_in    (clk_in),
    .rst       (rst),
    .btn_step  (btn_step),
    .step_pulse(step_pulse),
    .db_state  (db_state)
  );

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      tick_s1   <= 1'b0;
      tick_s2   <= 1'b0;
      tick_prev <= 1'b0;
      mode_s1   <= MODE_HALT;
      mode_s2   <= MODE_HALT;
      cpu_en    <= 1'b0;
    end else begin
      tick_s1   <= tick_in;
      tick_s2   <= tick_s1;
      tick_prev <= tick_s2;
      mode_s1   <= mode;
      mode_s2   <= mode_s1;
      cpu_en    <= en_d;
    end
  end

  assign tick_rise = tick_s2 & ~tick_prev;

  // A RUN->STEP switch could line up a tick and a step
  // pulse back to back; the ~cpu_en term keeps them apart.
  always_comb begin
    en_d = 1'b0;
    unique case (mode_s2)
      MODE_RUN:  en_d = tick_rise;
      MODE_STEP: en_d = step_pulse;
      default:   en_d = 1'b0;
    endcase
    en_d = en_d & ~cpu_en;
  end

`ifdef STEP_CNT_EN
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      en_cnt <= '0;
    end else if (cpu_en) begin
      en_cnt <= en_cnt + CNT_W'(1);
    end
  end
`else
  assign en_cnt = '0;
`endif

  assign dbg_state = db_state;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed scoreboard bench for step_ctrl.
// Expected pulse cycles are queued at stimulus time.
module tb_step_ctrl;

  localparam int DB = 20;
  localparam int CW = 4;

  logic          clk_in   = 1'b0;
  logic          rst      = 1'b0;
  logic          tick_in  = 1'b0;
  logic          btn_step = 1'b0;
  logic [1:0]    mode     = 2'b00;
  logic          cpu_en;
  logic [CW-1:0] en_cnt;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_pulse = 0;
  int exp_q[$];
  bit prev_en   = 1'b0;
  bit tick_free = 1'b0;

  step_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CW)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .tick_in  (tick_in),
    .btn_step (btn_step),
    .mode     (mode),
    .cpu_en   (cpu_en),
    .en_cnt   (en_cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt();
`ifdef STEP_CNT_EN
    return n_pulse % (1 << CW);
`else
    return 0;
`endif
  endfunction

  // Sample at the falling edge, then drive free-running tick.
  task automatic step();
    @(negedge clk_in);
    if (exp_q.size() > 0 && cyc > exp_q[0])
      chk("missed_pulse", cyc, exp_q.pop_front());
    if (cpu_en === 1'b1) begin
      chk("no_back2back", int'(prev_en), 0);
      if (exp_q.size() == 0)
        chk("unexp_pulse", cyc, -1);
      else
        chk("pulse_cyc", cyc, exp_q.pop_front());
    end
    prev_en = cpu_en;
    if (tick_free && (cyc % 31 == 0))
      tick_in = ~tick_in;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  // Tick sampled at edge cyc+1, pulse visible after edge cyc+3.
  task automatic tick_periods(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      exp_q.push_back(cyc + 3);
      n_pulse++;
      wait_n(31);
      tick_in = 1'b0;
      wait_n(31);
    end
  endtask

  // 2 sync edges, 1 edge into PRESS, DB counting edges.
  task automatic expect_step();
    exp_q.push_back(cyc + 3 + DB);
    n_pulse++;
  endtask

  initial begin
    #1;
    chk("rst_cpu_en", int'(cpu_en), 0);
    chk("rst_en_cnt", int'(en_cnt), 0);
    chk("rst_dbg", int'(dbg_state), 0);
    wait_n(2);
    rst = 1'b1;
    wait_n(2);

    mode = 2'b01;
    wait_n(4);
    tick_periods(10);
    wait_n(5);
    chk("run_en_cnt", int'(en_cnt), exp_cnt());
    chk("run_dbg", int'(dbg_state), 0);

    mode = 2'b10;
    wait_n(4);
    btn_step = 1'b1; wait_n(1);
    btn_step = 1'b0; wait_n(2);
    btn_step = 1'b1; wait_n(1);
    btn_step = 1'b0; wait_n(1);
    btn_step = 1'b1;
    expect_step();
    wait_n(100);
    chk("step_held", int'(dbg_state), 2);
    chk("step_en_cnt", int'(en_cnt), exp_cnt());
    btn_step = 1'b0; wait_n(1);
    btn_step = 1'b1; wait_n(2);
    btn_step = 1'b0;
    wait_n(40);
    chk("rel_dbg", int'(dbg_state), 0);
    chk("rel_en_cnt", int'(en_cnt), exp_cnt());

    mode = 2'b00;
    tick_free = 1'b1;
    wait_n(4);
    for (int i = 0; i < 3; i++) begin
      btn_step = 1'b1; wait_n(40);
      btn_step = 1'b0; wait_n(40);
    end
    tick_free = 1'b0;
    tick_in = 1'b0;
    wait_n(5);
    chk("halt_en_cnt", int'(en_cnt), exp_cnt());
    chk("halt_dbg", int'(dbg_state), 0);

    mode = 2'b01;
    wait_n(4);
    btn_step = 1'b1;
    wait_n(3 + DB + 5);
    chk("sw_held", int'(dbg_state), 2);
    mode = 2'b10;
    wait_n(10);
    btn_step = 1'b0;
    wait_n(40);
    chk("sw_dbg", int'(dbg_state), 0);
    chk("sw_en_cnt", int'(en_cnt), exp_cnt());
    btn_step = 1'b1;
    expect_step();
    wait_n(40);
    btn_step = 1'b0;
    wait_n(40);
    chk("new_press_cnt", int'(en_cnt), exp_cnt());

    mode = 2'b01;
    wait_n(4);
    tick_periods(5);
    wait_n(5);
    chk("wrap_en_cnt", int'(en_cnt), exp_cnt());

    mode = 2'b10;
    wait_n(4);
    btn_step = 1'b1;
    wait_n(10);
    chk("mid_press", int'(dbg_state), 1);
    @(posedge clk_in);
    #2 rst = 1'b0;
    #1;
    chk("arst_cpu_en", int'(cpu_en), 0);
    chk("arst_en_cnt", int'(en_cnt), 0);
    chk("arst_dbg", int'(dbg_state), 0);
    exp_q.delete();
    n_pulse = 0;
    prev_en = 1'b0;
    btn_step = 1'b0;
    wait_n(2);
    rst = 1'b1;
    wait_n(30);
    chk("post_rst_cnt", int'(en_cnt), exp_cnt());
    chk("post_rst_dbg", int'(dbg_state), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
